shifter_iter: RTL and testbench



---
 rtl/shifter_pkg.sv | 16 +
 rtl/shifter_iter_shift_step.sv | 28 ++
 rtl/shifter_iter.sv | 115 +++++++++++
 tb/tb_shifter_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the shift units: op encoding (also used by the barrel
// shifter) and the iterative shifter's FSM state encoding.
package shifter_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_iter_shift_step.sv
// Combinational single-bit step of a shift/rotate op.
// SHIFTER_ITER_SRA_EN turns op 10 from rotate-right into arithmetic-right.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] w_next
);

  always_comb begin
    w_next = w;
    case (op)
      OP_ROL: w_next = {w[WIDTH-2:0], w[WIDTH-1]};
      OP_SLL: w_next = {w[WIDTH-2:0], 1'b0};
`ifdef SHIFTER_ITER_SRA_EN
      OP_ROR: w_next = {w[WIDTH-1], w[WIDTH-1:1]};
`else
      OP_ROR: w_next = {w[0], w[WIDTH-1:1]};
`endif
      OP_SRL: w_next = {1'b0, w[WIDTH-1:1]};
      default: w_next = w;
    endcase
  end

endmodule

// File: rtl/shifter_iter.sv
// Bit-serial shift/rotate unit: one bit position per cycle, valid/ready on both sides.
// Op 10 behaviour is selected by SHIFTER_ITER_SRA_EN inside shift_step.
module shifter_iter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w      (work_q),
    .op     (op_q),
    .w_next (step_out)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d      = in_data;
          op_d        = in_op;
          remaining_d = in_cnt;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = (in_cnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d      = step_out;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_data_d  = step_out;
        end
      end
      ST_DONE: begin
        // A zero-count request enters DONE unpresented; it is shown one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = work_q;
        end else if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      op_q        <= OP_ROL;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shifter_iter.sv
// Directed bench for shifter_iter: hand-computed results, latency, backpressure, reset.
module tb_shifter_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  shifter_iter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a falling edge; returns just after the accept edge.
  task automatic issue(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_op    = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_cnt   = 4'($urandom);
    in_op    = 2'($urandom);
  endtask

  // Cycles from the accept edge until out_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] d, input logic [3:0] c,
                     input logic [1:0] o, input logic [15:0] exp_data, input int exp_lat);
    int lat;
    issue(d, c, o);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    $display("txn %s data=%04h cnt=%0d op=%0d -> out=%04h lat=%0d", tag, d, c, o, out_data, lat);
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n;
    int seen_lat;
    logic [15:0] seen_data;
    logic [15:0] exp_sra;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ROL by 1 with detailed handshake observation
    issue(16'h8001, 4'd1, 2'b00);
    check("rol1_in_ready_low", 32'(in_ready), 32'd0);
    check("rol1_busy", 32'(busy), 32'd1);
    check("rol1_no_early_valid", 32'(out_valid), 32'd0);
    wait_valid(lat);
    check("rol1_lat", 32'(lat), 32'd1);
    check("rol1_data", 32'(out_data), 32'h0003);
    check("rol1_in_ready_done", 32'(in_ready), 32'd0);
    $display("txn rol1 data=8001 cnt=1 op=0 -> out=%04h lat=%0d", out_data, lat);
    handshake("rol1");

    // SLL by 4 with out_ready held high throughout
    @(negedge clk);
    out_ready = 1'b1;
    issue(16'h00FF, 4'd4, 2'b01);
    n = 0;
    seen_lat = 0;
    seen_data = '0;
    while (busy && n < 40) begin
      n++;
      if (out_valid && seen_lat == 0) begin
        seen_lat  = n - 1;
        seen_data = out_data;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    check("sll4_lat", 32'(seen_lat), 32'd4);
    check("sll4_data", 32'(seen_data), 32'h0FF0);
    check("sll4_busy_cycles", 32'(n), 32'd5);
    $display("txn sll4 data=00ff cnt=4 op=1 -> out=%04h lat=%0d busy=%0d", seen_data, seen_lat, n);

    run("srl15", 16'h8001, 4'd15, 2'b11, 16'h0001, 15);
    run("cnt0_srl", 16'hA5A5, 4'd0, 2'b11, 16'hA5A5, 1);
    run("cnt0_ror", 16'h1234, 4'd0, 2'b10, 16'h1234, 1);
    run("rol8", 16'h1234, 4'd8, 2'b00, 16'h3412, 8);
    run("rol15", 16'h0001, 4'd15, 2'b00, 16'h8000, 15);
`ifdef SHIFTER_ITER_SRA_EN
    exp_sra = 16'hC001;
`else
    exp_sra = 16'h4001;
`endif
    run("op10", 16'h8002, 4'd1, 2'b10, exp_sra, 1);

    // Backpressure: result must hold while in_valid/in_data toggle
    issue(16'h00F0, 4'd2, 2'b11);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_data_hold", 32'(out_data), 32'h003C);
      check("bp_no_accept", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    $display("txn bp data=00f0 cnt=2 op=3 -> held 003c for 5 cycles");

    // Reset in the middle of a long shift
    issue(16'h5555, 4'd10, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    $display("txn midrst data=5555 cnt=10 op=0 -> discarded");
    run("post_rst_sll2", 16'h0001, 4'd2, 2'b01, 16'h0004, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
